// File: rtl/crg_pkg.sv
// Shared types for the CRG delay generator.
// Channel modes, channel states and a select-width helper.
package crg_pkg;

   typedef enum logic {
      DLY_ONESHOT  = 1'b0,
      DLY_PERIODIC = 1'b1
   } dly_mode_e;

   typedef enum logic [1:0] {
      DLY_IDLE,
      DLY_COUNT,
      DLY_DONE
   } dly_state_e;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/delay_chan.sv
// One delay channel: state, counter and active copy of (D, mode).
// Ports: clk_i, arst_i, start_i, abort_i, delay_i, mode_i -> busy_o, tick_o, done_o.
module delay_chan
   import crg_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int DEF_DELAY  = 128,
   parameter bit AUTO_START = 1'b1
) (
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [CNT_W-1:0] delay_i,
   input  dly_mode_e        mode_i,
   output logic             busy_o,
   output logic             tick_o,
   output logic             done_o
);

   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DELAY);
   localparam dly_state_e RST_ST =
      AUTO_START ? DLY_COUNT : DLY_IDLE;

   dly_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] dact_q, dact_d;
   dly_mode_e        mode_q, mode_d;
   logic             hit;

   // Terminal count; never true past D_act-1 so no wrap.
   assign hit = (state_q == DLY_COUNT) &&
                (cnt_q == dact_q - ONE);

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= RST_ST;
         cnt_q   <= '0;
         dact_q  <= DEF_D;
         mode_q  <= DLY_ONESHOT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dact_q  <= dact_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dact_d  = dact_q;
      mode_d  = mode_q;
      priority case (1'b1)
         abort_i: begin
            state_d = DLY_IDLE;
            cnt_d   = '0;
         end
         start_i: begin
            state_d = DLY_COUNT;
            cnt_d   = '0;
            // D=0 behaves as D=1
            dact_d  = (delay_i == '0) ? ONE : delay_i;
            mode_d  = mode_i;
         end
         hit: begin
            cnt_d = '0;
            if (mode_q == DLY_ONESHOT) begin
               state_d = DLY_DONE;
            end
         end
         (state_q == DLY_COUNT): begin
            cnt_d = cnt_q + ONE;
         end
         default: ;
      endcase
   end

   // Reset masks the decode for the DEF_DELAY=1 auto-start case.
   assign busy_o = (state_q == DLY_COUNT);
   assign tick_o = hit & ~arst_i;
   assign done_o = (tick_o & (mode_q == DLY_ONESHOT)) |
                   (state_q == DLY_DONE);

endmodule

// File: rtl/delay_gen_multi.sv
// Multi-channel programmable delay generator: cfg register file plus channels.
// Ports: clk_i, arst_i, cfg_we_i/ch/delay/mode, start_i, abort_i -> busy_o, tick_o, done_o.
module delay_gen_multi
   import crg_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 8,
   parameter int DEF_DELAY  = 128,
   parameter bit AUTO_START = 1'b1,
   localparam int CH_W      = ch_w(NUM_CH)
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              cfg_we_i,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic [CNT_W-1:0]  cfg_delay_i,
   input  logic              cfg_mode_i,
   input  logic [NUM_CH-1:0] start_i,
   input  logic [NUM_CH-1:0] abort_i,
   output logic [NUM_CH-1:0] busy_o,
   output logic [NUM_CH-1:0] tick_o,
   output logic [NUM_CH-1:0] done_o
);

   if (NUM_CH < 1 || DEF_DELAY < 1 ||
       DEF_DELAY > (2**CNT_W) - 1) begin : g_bad_param
      $error("delay_gen_multi: bad parameters");
   end

   localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DELAY);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic             sel;
      logic [CNT_W-1:0] cfg_d_q;
      dly_mode_e        cfg_m_q;
      logic [CNT_W-1:0] eff_d;
      dly_mode_e        eff_m;

      // Out-of-range addresses match no channel.
      assign sel = cfg_we_i && (cfg_ch_i == CH_W'(c));

      always_ff @(posedge clk_i or posedge arst_i) begin
         if (arst_i) begin
            cfg_d_q <= DEF_D;
            cfg_m_q <= DLY_ONESHOT;
         end else if (sel) begin
            cfg_d_q <= cfg_delay_i;
            cfg_m_q <= dly_mode_e'(cfg_mode_i);
         end
      end

      // Same-cycle write bypasses into a start.
      assign eff_d = sel ? cfg_delay_i : cfg_d_q;
      assign eff_m = sel ? dly_mode_e'(cfg_mode_i) : cfg_m_q;

      delay_chan #(
         .CNT_W      (CNT_W),
         .DEF_DELAY  (DEF_DELAY),
         .AUTO_START (AUTO_START)
      ) u_chan (
         .clk_i   (clk_i),
         .arst_i  (arst_i),
         .start_i (start_i[c]),
         .abort_i (abort_i[c]),
         .delay_i (eff_d),
         .mode_i  (eff_m),
         .busy_o  (busy_o[c]),
         .tick_o  (tick_o[c]),
         .done_o  (done_o[c])
      );
   end

endmodule
